axi_latency_sink: RTL and testbench

AXI_LATENCY_SINK -- requirements
Module: axi_latency_sink

---
 rtl/axi_latency_sink_pkg.sv | 20 ++
 rtl/sink_fifo.sv | 43 ++++
 rtl/axi_latency_sink.sv | 192 +++++++++++++++++++
 tb/tb_axi_latency_sink.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_latency_sink_pkg.sv
// Shared types and constants for the AXI latency sink: response codes, cycle-counter width
// and the read-queue entry layout.
package axi_latency_sink_pkg;

    localparam int CNT_W    = 16;
    localparam int MAX_ID_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // The id field is sized for the widest supported ID; the top zero-extends into it.
    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [7:0]          len;
        logic [CNT_W-1:0]    ts;
    } rd_entry_t;

endpackage

// File: rtl/sink_fifo.sv
// Synchronous FIFO with full/empty flags; pointers carry a wrap bit so all DEPTH entries are usable.
// Head data is presented combinationally on pop_data.
module sink_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage carries no reset; validity is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/axi_latency_sink.sv
// AXI4 slave that discards writes and answers reads after a fixed latency with OKAY responses.
// Optional macro AXI_SINK_RDATA_PATTERN_EN: RDATA carries ARADDR[31:0] + 16*beat replicated, else zero.
module axi_latency_sink
    import axi_latency_sink_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 16,
    parameter int C_S_AXI_DATA_WIDTH = 128,
    parameter int C_S_AXI_ADDR_WIDTH = 40,
    parameter int QUEUE_DEPTH        = 32,
    parameter int READ_LATENCY       = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWLOCK,
    input  logic [3:0]                      S_AXI_AWCACHE,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic [3:0]                      S_AXI_AWQOS,
    input  logic [3:0]                      S_AXI_AWREGION,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARLOCK,
    input  logic [3:0]                      S_AXI_ARCACHE,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic [3:0]                      S_AXI_ARQOS,
    input  logic [3:0]                      S_AXI_ARREGION,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] age;
    logic [7:0]       beat;
    logic             elig_q;
    logic             head_elig;
    logic             r_fire;

    rd_entry_t rd_push_entry;
    rd_entry_t rd_head;
    logic      rd_push, rd_pop, rd_full, rd_empty;

`ifdef AXI_SINK_RDATA_PATTERN_EN
    localparam int RD_W = $bits(rd_entry_t) + 32;
    logic [RD_W-1:0] rd_push_data;
    logic [RD_W-1:0] rd_pop_data;
    logic [31:0]     head_addr;
    logic [31:0]     beat_word;

    assign rd_push_data = {S_AXI_ARADDR[31:0], rd_push_entry};
    assign rd_head      = rd_entry_t'(rd_pop_data[$bits(rd_entry_t)-1:0]);
    assign head_addr    = rd_pop_data[RD_W-1 -: 32];
    assign beat_word    = head_addr + {20'd0, beat, 4'd0};
    assign S_AXI_RDATA  = head_elig ? {(C_S_AXI_DATA_WIDTH/32){beat_word}} : '0;
`else
    localparam int RD_W = $bits(rd_entry_t);
    logic [RD_W-1:0] rd_push_data;
    logic [RD_W-1:0] rd_pop_data;

    assign rd_push_data = rd_push_entry;
    assign rd_head      = rd_entry_t'(rd_pop_data);
    assign S_AXI_RDATA  = '0;
`endif

    always_comb begin
        rd_push_entry     = '0;
        rd_push_entry.id  = MAX_ID_W'(S_AXI_ARID);
        rd_push_entry.len = S_AXI_ARLEN;
        rd_push_entry.ts  = cnt;
    end

    assign S_AXI_ARREADY = S_AXI_ARESETN && !rd_full;
    assign rd_push       = S_AXI_ARVALID && S_AXI_ARREADY;

    // Age is modulo 2^16; once eligible the head stays eligible even if the age wraps.
    assign age       = cnt - rd_head.ts;
    assign head_elig = !rd_empty && (elig_q || (age >= CNT_W'(READ_LATENCY)));

    assign S_AXI_RVALID = head_elig;
    assign S_AXI_RLAST  = head_elig && (beat == rd_head.len);
    assign S_AXI_RID    = head_elig ? rd_head.id[C_S_AXI_ID_WIDTH-1:0] : '0;
    assign S_AXI_RRESP  = RESP_OKAY;
    assign r_fire       = S_AXI_RVALID && S_AXI_RREADY;
    assign rd_pop       = r_fire && S_AXI_RLAST;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            cnt    <= '0;
            beat   <= '0;
            elig_q <= 1'b0;
        end else begin
            cnt <= cnt + CNT_W'(1);
            if (rd_pop) begin
                beat   <= '0;
                elig_q <= 1'b0;
            end else begin
                if (r_fire)    beat   <= beat + 8'd1;
                if (head_elig) elig_q <= 1'b1;
            end
        end
    end

    sink_fifo #(
        .WIDTH (RD_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_rd_fifo (
        .clk       (S_AXI_ACLK),
        .rst_n     (S_AXI_ARESETN),
        .push      (rd_push),
        .push_data (rd_push_data),
        .pop       (rd_pop),
        .pop_data  (rd_pop_data),
        .full      (rd_full),
        .empty     (rd_empty)
    );

    logic                        aw_push, aw_full, aw_empty;
    logic [C_S_AXI_ID_WIDTH-1:0] aw_head;
    logic                        b_full, b_empty, b_pop;
    logic [C_S_AXI_ID_WIDTH-1:0] b_head;
    logic                        w_last_fire;

    assign S_AXI_AWREADY = S_AXI_ARESETN && !aw_full;
    assign aw_push       = S_AXI_AWVALID && S_AXI_AWREADY;

    // Write data is only accepted once its address is queued and a response slot is free.
    assign S_AXI_WREADY = S_AXI_ARESETN && !aw_empty && !b_full;
    assign w_last_fire  = S_AXI_WVALID && S_AXI_WREADY && S_AXI_WLAST;

    assign S_AXI_BVALID = !b_empty;
    assign S_AXI_BID    = S_AXI_BVALID ? b_head : '0;
    assign S_AXI_BRESP  = RESP_OKAY;
    assign b_pop        = S_AXI_BVALID && S_AXI_BREADY;

    sink_fifo #(
        .WIDTH (C_S_AXI_ID_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_aw_fifo (
        .clk       (S_AXI_ACLK),
        .rst_n     (S_AXI_ARESETN),
        .push      (aw_push),
        .push_data (S_AXI_AWID),
        .pop       (w_last_fire),
        .pop_data  (aw_head),
        .full      (aw_full),
        .empty     (aw_empty)
    );

    sink_fifo #(
        .WIDTH (C_S_AXI_ID_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_b_fifo (
        .clk       (S_AXI_ACLK),
        .rst_n     (S_AXI_ARESETN),
        .push      (w_last_fire),
        .push_data (aw_head),
        .pop       (b_pop),
        .pop_data  (b_head),
        .full      (b_full),
        .empty     (b_empty)
    );

    wire unused_inputs = &{1'b0, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
                           S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                           S_AXI_AWREGION, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_ARADDR,
                           S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLOCK, S_AXI_ARCACHE,
                           S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION, rd_head};

endmodule

// File: tb/tb_axi_latency_sink.sv
// Scoreboard bench for axi_latency_sink: stimulus pushes expected R beats / B ids, a negedge
// monitor pops and compares on every handshake; directed timing checks run inline.
`timescale 1ns/1ps
module tb_axi_latency_sink;

    localparam int IDW = 16;
    localparam int DW  = 128;
    localparam int AW  = 40;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [IDW-1:0]  awid = '0;
    logic [AW-1:0]   awaddr = '0;
    logic [7:0]      awlen = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [DW-1:0]   wdata = '0;
    logic [DW/8-1:0] wstrb = '1;
    logic            wlast = 1'b0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [IDW-1:0]  bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b0;
    logic [IDW-1:0]  arid = '0;
    logic [AW-1:0]   araddr = '0;
    logic [7:0]      arlen = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [IDW-1:0]  rid;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready = 1'b0;

    always #5 clk = ~clk;

    axi_latency_sink #(
        .C_S_AXI_ID_WIDTH   (IDW),
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (AW),
        .QUEUE_DEPTH        (32),
        .READ_LATENCY       (4)
    ) dut (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESETN  (rst_n),
        .S_AXI_AWID     (awid),
        .S_AXI_AWADDR   (awaddr),
        .S_AXI_AWLEN    (awlen),
        .S_AXI_AWSIZE   (3'd4),
        .S_AXI_AWBURST  (2'b01),
        .S_AXI_AWLOCK   (1'b0),
        .S_AXI_AWCACHE  (4'd0),
        .S_AXI_AWPROT   (3'd0),
        .S_AXI_AWQOS    (4'd0),
        .S_AXI_AWREGION (4'd0),
        .S_AXI_AWVALID  (awvalid),
        .S_AXI_AWREADY  (awready),
        .S_AXI_WDATA    (wdata),
        .S_AXI_WSTRB    (wstrb),
        .S_AXI_WLAST    (wlast),
        .S_AXI_WVALID   (wvalid),
        .S_AXI_WREADY   (wready),
        .S_AXI_BID      (bid),
        .S_AXI_BRESP    (bresp),
        .S_AXI_BVALID   (bvalid),
        .S_AXI_BREADY   (bready),
        .S_AXI_ARID     (arid),
        .S_AXI_ARADDR   (araddr),
        .S_AXI_ARLEN    (arlen),
        .S_AXI_ARSIZE   (3'd4),
        .S_AXI_ARBURST  (2'b01),
        .S_AXI_ARLOCK   (1'b0),
        .S_AXI_ARCACHE  (4'd0),
        .S_AXI_ARPROT   (3'd0),
        .S_AXI_ARQOS    (4'd0),
        .S_AXI_ARREGION (4'd0),
        .S_AXI_ARVALID  (arvalid),
        .S_AXI_ARREADY  (arready),
        .S_AXI_RID      (rid),
        .S_AXI_RDATA    (rdata),
        .S_AXI_RRESP    (rresp),
        .S_AXI_RLAST    (rlast),
        .S_AXI_RVALID   (rvalid),
        .S_AXI_RREADY   (rready)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic           last;
        logic [DW-1:0]  data;
    } rbeat_t;

    rbeat_t         r_exp[$];
    logic [IDW-1:0] b_exp[$];
    rbeat_t         mon_r;
    logic [IDW-1:0] mon_b;
    int             n_cmp = 0;
    int             n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rdata(input logic [31:0] addr, input int beat);
`ifdef AXI_SINK_RDATA_PATTERN_EN
        logic [31:0] w;
        w = addr + 32'(16 * beat);
        return {(DW/32){w}};
`else
        return '0;
`endif
    endfunction

    task automatic push_read(input logic [IDW-1:0] id, input logic [7:0] len, input logic [31:0] addr);
        rbeat_t e;
        for (int b = 0; b <= int'(len); b++) begin
            e.id   = id;
            e.last = (b == int'(len));
            e.data = exp_rdata(addr, b);
            r_exp.push_back(e);
        end
    endtask

    // Returns just after the handshake edge, i.e. in cycle 1 relative to the handshake cycle.
    task automatic ar_issue(input logic [IDW-1:0] id, input logic [7:0] len, input logic [31:0] addr);
        int guard;
        guard = 0;
        @(posedge clk); #1;
        arvalid = 1'b1; arid = id; arlen = len; araddr = AW'(addr);
        @(negedge clk);
        while (!arready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("ar_accept", arready, 1);
        push_read(id, len, addr);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int g;
        g = 0;
        while ((r_exp.size() != 0 || b_exp.size() != 0) && g < budget) begin
            @(negedge clk);
            g++;
        end
        check({name, "_r_left"}, r_exp.size(), 0);
        check({name, "_b_left"}, b_exp.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            if (r_exp.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL r_unexpected: got beat id 0x%0h, want none", rid);
            end else begin
                mon_r = r_exp.pop_front();
                check("r_id", rid, mon_r.id);
                check("r_last", rlast, mon_r.last);
                check("r_data", rdata, mon_r.data);
                check("r_resp", rresp, 0);
            end
        end
        if (rst_n && bvalid && bready) begin
            if (b_exp.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL b_unexpected: got bid 0x%0h, want none", bid);
            end else begin
                mon_b = b_exp.pop_front();
                check("b_id", bid, mon_b);
                check("b_resp", bresp, 0);
            end
        end
    end

    initial begin
        int g;
        int bad;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_arready", arready, 0);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rid", rid, 0);
        check("rst_bid", bid, 0);
        check("rst_rdata", rdata, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_arready", arready, 1);
        check("rel_awready", awready, 1);

        // Single AR, latency 4: RVALID first in cycle 4 after the handshake cycle
        rready = 1'b1;
        ar_issue(16'h5, 8'd3, 32'h1000);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("r_early", rvalid, 0);
        end
        @(negedge clk);
        check("r_first_cycle4", rvalid, 1);
        check("r_first_id", rid, 16'h5);
        repeat (4) @(negedge clk);
        check("r_after_burst", rvalid, 0);
        check("r_burst_done", r_exp.size(), 0);

        // Two queued bursts, responses in order
        ar_issue(16'h1, 8'd1, 32'h2000);
        ar_issue(16'h2, 8'd2, 32'h3000);
        drain("two_bursts", 100);

        // Fill the read queue with RREADY low, then release one burst
        rready = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b1;
        arlen = 8'd0;
        for (int i = 0; i < 32; i++) begin
            arid = IDW'(i);
            araddr = AW'(32'h4000 + i * 64);
            @(negedge clk);
            check("ar_fill", arready, 1);
            push_read(IDW'(i), 8'd0, 32'h4000 + i * 64);
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        @(negedge clk);
        check("ar_full", arready, 0);
        @(posedge clk); #1;
        rready = 1'b1;
        @(negedge clk);
        check("r_full_head_valid", rvalid, 1);
        @(posedge clk); #1;
        rready = 1'b0;
        @(negedge clk);
        check("ar_free_after_pop", arready, 1);
        rready = 1'b1;
        drain("fill", 200);

        // W before AW stalls; B returns the AW id and holds under backpressure
        bready = 1'b0;
        @(posedge clk); #1;
        wvalid = 1'b1;
        wlast = 1'b1;
        wdata = {4{32'hDEADBEEF}};
        repeat (3) begin
            @(negedge clk);
            check("w_stall", wready, 0);
        end
        @(posedge clk); #1;
        awvalid = 1'b1;
        awid = 16'h9;
        @(negedge clk);
        check("aw_accept", awready, 1);
        check("w_stall_aw_cycle", wready, 0);
        b_exp.push_back(16'h9);
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(negedge clk);
        check("w_after_aw", wready, 1);
        @(posedge clk); #1;
        wvalid = 1'b0;
        wlast = 1'b0;
        @(negedge clk);
        check("b_valid", bvalid, 1);
        check("b_id_direct", bid, 16'h9);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("b_hold", bvalid, 1);
            check("b_hold_id", bid, 16'h9);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        check("b_single_pop", bvalid, 0);

        // Two AWs then two 2-beat W bursts: B in AW order
        bready = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b1;
        awid = 16'hA;
        @(negedge clk);
        check("aw_a", awready, 1);
        b_exp.push_back(16'hA);
        @(posedge clk); #1;
        awid = 16'hB;
        @(negedge clk);
        check("aw_b", awready, 1);
        b_exp.push_back(16'hB);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wlast = (j % 2 == 1);
            @(negedge clk);
            check("w_burst_ready", wready, 1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        wlast = 1'b0;
        drain("writes", 50);

        // Eligible head held across a full counter wrap with RREADY low
        rready = 1'b0;
        ar_issue(16'h3, 8'd1, 32'h5000);
        g = 0;
        while (!rvalid && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("r_elig", rvalid, 1);
        bad = 0;
        repeat (66000) begin
            @(negedge clk);
            if (!(rvalid && rid == 16'h3 && !rlast && rdata == exp_rdata(32'h5000, 0))) bad++;
        end
        check("r_hold_wrap", bad, 0);
        @(posedge clk); #1;
        rready = 1'b1;
        drain("wrap", 20);

        // Reset in the middle of an 8-beat burst (at beat 2)
        ar_issue(16'h7, 8'd7, 32'h6000);
        g = 0;
        while (!rvalid && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("r_mid_start", rvalid, 1);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("r_reset_drop", rvalid, 0);
        check("r_reset_rlast", rlast, 0);
        check("r_reset_rid", rid, 0);
        check("r_reset_arready", arready, 0);
        check("r_reset_left", r_exp.size(), 6);
        r_exp.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel2_arready", arready, 1);
        check("rel2_awready", awready, 1);
        check("rel2_rvalid", rvalid, 0);
        check("rel2_bvalid", bvalid, 0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (rvalid) bad++;
        end
        check("r_no_residual", bad, 0);
        check("end_r_queue", r_exp.size(), 0);
        check("end_b_queue", b_exp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
